pong_engine: RTL and testbench

Parametrised two-player Pong game engine: game state, ball physics, scoring and the pixel renderer in one block. It sits between the button inputs and `hdmi_video`. It consumes the pixel coordinates from `hdmi_video` and returns a registered 24-bit colour. All motion is stepped once per video frame on `frame_tick`, not by free-running counter edges.

---
 rtl/pong_if.sv | 31 +++
 rtl/pong_engine.sv | 247 ++++++++++++++++++++++++
 tb/tb_pong_engine.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pong_if.sv
// Pong engine port bundle: frame/button/pixel inputs, colour and game status outputs.
// Latency: none, wires only.
// Backpressure: none; the engine consumes every pixel coordinate and frame tick it sees.
interface pong_if;
  logic        frame_tick;
  logic        start;
  logic        l_up;
  logic        l_dn;
  logic        r_up;
  logic        r_dn;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [23:0] color;
  logic [2:0]  state;
  logic [3:0]  score_l;
  logic [3:0]  score_r;
  logic        winner;
  logic        point_pulse;

  // Driven side: video timing plus buttons; observes the engine outputs.
  modport master (
    output frame_tick, start, l_up, l_dn, r_up, r_dn, x, y,
    input  color, state, score_l, score_r, winner, point_pulse
  );

  // Engine side.
  modport slave (
    input  frame_tick, start, l_up, l_dn, r_up, r_dn, x, y,
    output color, state, score_l, score_r, winner, point_pulse
  );
endinterface

// File: rtl/pong_engine.sv
// Two-player Pong: paddles, ball physics, scoring FSM and pixel renderer.
// Latency: colour 1 cycle after x/y; game state steps once per frame_tick.
// Backpressure: none; frame_tick and pixel coordinates are always accepted.
module pong_engine #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int PADDLE_SIZE   = 64,
  parameter int PADDLE_WIDTH  = 8,
  parameter int PADDLE_STEP   = 4,
  parameter int BALL_SIZE     = 8,
  parameter int BALL_SPEED    = 2,
  parameter int SCORE_MAX     = 9,
  parameter int SERVE_DELAY   = 60
) (
  input logic   clk_25mhz,
  input logic   reset,
  pong_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  // All geometry is compared in 11 bits so sums of 10-bit positions never wrap.
  localparam logic [10:0] W      = 11'(SCREEN_WIDTH);
  localparam logic [10:0] H      = 11'(SCREEN_HEIGHT);
  localparam logic [10:0] PS     = 11'(PADDLE_SIZE);
  localparam logic [10:0] PW     = 11'(PADDLE_WIDTH);
  localparam logic [10:0] PSTEP  = 11'(PADDLE_STEP);
  localparam logic [10:0] BS     = 11'(BALL_SIZE);
  localparam logic [10:0] BSPD   = 11'(BALL_SPEED);
  localparam logic [10:0] NET_L  = 11'(SCREEN_WIDTH / 2 - 1);
  localparam logic [10:0] NET_R  = 11'(SCREEN_WIDTH / 2);
  localparam logic [9:0]  PY_MAX = 10'(SCREEN_HEIGHT - PADDLE_SIZE);
  localparam logic [9:0]  PY_MID = 10'((SCREEN_HEIGHT - PADDLE_SIZE) / 2);
  localparam logic [9:0]  BX_MID = 10'((SCREEN_WIDTH - BALL_SIZE) / 2);
  localparam logic [9:0]  BY_MID = 10'((SCREEN_HEIGHT - BALL_SIZE) / 2);
  localparam logic [9:0]  BY_MAX = 10'(SCREEN_HEIGHT - BALL_SIZE);
  localparam logic [9:0]  BX_LHIT = 10'(PADDLE_WIDTH);
  localparam logic [9:0]  BX_RHIT = 10'(SCREEN_WIDTH - PADDLE_WIDTH - BALL_SIZE);
  localparam logic [3:0]  SMAX   = 4'(SCORE_MAX);
  localparam logic [15:0] SDELAY = 16'(SERVE_DELAY);

  state_t      r_state;
  logic [3:0]  r_score_l;
  logic [3:0]  r_score_r;
  logic        r_winner;
  logic        r_point_pulse;
  logic        r_scorer;      // 0 = left scored last point, 1 = right
  logic [23:0] r_color;
  logic [9:0]  r_pl_y;
  logic [9:0]  r_pr_y;
  logic [9:0]  r_ball_x;
  logic [9:0]  r_ball_y;
  logic        r_dir_x;       // 1 = moving right
  logic        r_dir_y;       // 1 = moving down
  logic [15:0] r_serve_cnt;

  logic [10:0] w_bx, w_by, w_pl, w_pr, w_x, w_y;
  logic [9:0]  w_bx_nxt, w_by_nxt;
  logic        w_dx_nxt, w_dy_nxt;
  logic        w_miss, w_scorer;
  logic        w_in_ball, w_in_pl, w_in_pr, w_in_net;

  assign w_bx = {1'b0, r_ball_x};
  assign w_by = {1'b0, r_ball_y};
  assign w_pl = {1'b0, r_pl_y};
  assign w_pr = {1'b0, r_pr_y};
  assign w_x  = {1'b0, bus.x};
  assign w_y  = {1'b0, bus.y};

  assign bus.state       = r_state;
  assign bus.score_l     = r_score_l;
  assign bus.score_r     = r_score_r;
  assign bus.winner      = r_winner;
  assign bus.point_pulse = r_point_pulse;
  assign bus.color       = r_color;

  // Paddle step: up saturates at 0, down at the bottom edge, both/none hold.
  function automatic logic [9:0] paddle_next(input logic [9:0] py, input logic up,
                                             input logic dn);
    logic [10:0] down_y;
    down_y = {1'b0, py} + PSTEP;
    if (up && !dn) return ({1'b0, py} >= PSTEP) ? py - PSTEP[9:0] : 10'd0;
    if (dn && !up) return (down_y > {1'b0, PY_MAX}) ? PY_MAX : down_y[9:0];
    return py;
  endfunction

  // One frame of ball motion against walls and the paddles as they stand now.
  always_comb begin
    w_bx_nxt = r_ball_x;
    w_by_nxt = r_ball_y;
    w_dx_nxt = r_dir_x;
    w_dy_nxt = r_dir_y;
    w_miss   = 1'b0;
    w_scorer = 1'b0;
    if (!r_dir_y) begin
      if (w_by < BSPD) begin
        w_by_nxt = 10'd0;
        w_dy_nxt = 1'b1;
      end else begin
        w_by_nxt = 10'(w_by - BSPD);
      end
    end else begin
      if (w_by + BS + BSPD > H) begin
        w_by_nxt = BY_MAX;
        w_dy_nxt = 1'b0;
      end else begin
        w_by_nxt = 10'(w_by + BSPD);
      end
    end
    if (!r_dir_x) begin
      if (w_bx < PW + BSPD) begin
        if ((w_by + BS > w_pl) && (w_by < w_pl + PS)) begin
          w_bx_nxt = BX_LHIT;
          w_dx_nxt = 1'b1;
        end else begin
          w_miss   = 1'b1;
          w_scorer = 1'b1;
        end
      end else begin
        w_bx_nxt = 10'(w_bx - BSPD);
      end
    end else begin
      if (w_bx + BS + BSPD > W - PW) begin
        if ((w_by + BS > w_pr) && (w_by < w_pr + PS)) begin
          w_bx_nxt = BX_RHIT;
          w_dx_nxt = 1'b0;
        end else begin
          w_miss   = 1'b1;
          w_scorer = 1'b0;
        end
      end else begin
        w_bx_nxt = 10'(w_bx + BSPD);
      end
    end
  end

  // Game FSM: paddles, ball, scores and serve timing, all registered.
  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_score_l     <= 4'd0;
      r_score_r     <= 4'd0;
      r_winner      <= 1'b0;
      r_point_pulse <= 1'b0;
      r_scorer      <= 1'b0;
      r_pl_y        <= PY_MID;
      r_pr_y        <= PY_MID;
      r_ball_x      <= BX_MID;
      r_ball_y      <= BY_MID;
      r_dir_x       <= 1'b1;
      r_dir_y       <= 1'b1;
      r_serve_cnt   <= 16'd0;
    end else begin
      r_point_pulse <= 1'b0;
      if (bus.frame_tick && r_state != S_OVER) begin
        r_pl_y <= paddle_next(r_pl_y, bus.l_up, bus.l_dn);
        r_pr_y <= paddle_next(r_pr_y, bus.r_up, bus.r_dn);
      end
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state     <= S_SERVE;
            r_serve_cnt <= SDELAY;
          end
        end
        S_SERVE: begin
          if (bus.frame_tick) begin
            if (r_serve_cnt <= 16'd1) begin
              r_state     <= S_PLAY;
              r_serve_cnt <= 16'd0;
            end else begin
              r_serve_cnt <= r_serve_cnt - 16'd1;
            end
          end
        end
        S_PLAY: begin
          if (bus.frame_tick) begin
            if (w_miss) begin
              // Ball freezes where it crossed the goal line.
              r_state       <= S_POINT;
              r_point_pulse <= 1'b1;
              r_scorer      <= w_scorer;
              if (w_scorer) r_score_r <= r_score_r + 4'd1;
              else          r_score_l <= r_score_l + 4'd1;
            end else begin
              r_ball_x <= w_bx_nxt;
              r_ball_y <= w_by_nxt;
              r_dir_x  <= w_dx_nxt;
              r_dir_y  <= w_dy_nxt;
            end
          end
        end
        S_POINT: begin
          if ((r_scorer ? r_score_r : r_score_l) == SMAX) begin
            r_state  <= S_OVER;
            r_winner <= r_scorer;
          end else begin
            // Serve toward whoever conceded, with the vertical direction flipped.
            r_state     <= S_SERVE;
            r_ball_x    <= BX_MID;
            r_ball_y    <= BY_MID;
            r_dir_x     <= ~r_scorer;
            r_dir_y     <= ~r_dir_y;
            r_serve_cnt <= SDELAY;
          end
        end
        S_OVER: begin
          if (bus.start) begin
            r_state     <= S_SERVE;
            r_score_l   <= 4'd0;
            r_score_r   <= 4'd0;
            r_ball_x    <= BX_MID;
            r_ball_y    <= BY_MID;
            r_serve_cnt <= SDELAY;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_in_ball = (r_state != S_OVER) && (w_x >= w_bx) && (w_x < w_bx + BS) &&
                     (w_y >= w_by) && (w_y < w_by + BS);
  assign w_in_pl   = (w_x < PW) && (w_y >= w_pl) && (w_y < w_pl + PS);
  assign w_in_pr   = (w_x >= W - PW) && (w_x < W) && (w_y >= w_pr) && (w_y < w_pr + PS);
  assign w_in_net  = ((w_x == NET_L) || (w_x == NET_R)) && !bus.y[4];

  // Pixel colour, ball over paddles over net over background.
  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      r_color <= 24'h000000;
    end else if (w_in_ball || w_in_pl || w_in_pr) begin
      r_color <= 24'hFFFFFF;
    end else if (w_in_net) begin
      r_color <= 24'h808080;
    end else begin
      r_color <= 24'h000000;
    end
  end

endmodule

// File: tb/tb_pong_engine.sv
// Bench for pong_engine: directed rallies with hand-computed trajectories.
// Expected values are queued by the driver; the monitor drains them and checks point pulses.
// Watchdog bounds the run.
module tb_pong_engine;

  localparam int K_STATE = 0, K_SL = 1, K_SR = 2, K_WIN = 3, K_BX = 4, K_BY = 5;
  localparam int K_DX = 6, K_DY = 7, K_PL = 8, K_PR = 9, K_COLOR = 10, K_PQ = 11;
  localparam logic [23:0] WHT = 24'hFFFFFF;
  localparam logic [23:0] GRY = 24'h808080;

  typedef struct { int kind; logic [23:0] val; } exp_t;
  typedef struct { logic [3:0] sl; logic [3:0] sr; } pt_t;

  logic clk = 1'b0;
  logic rst;
  pong_if bus();

  pong_engine dut (.clk_25mhz(clk), .reset(rst), .bus(bus));

  always #20 clk = ~clk;

  exp_t exp_q[$];
  pt_t  pt_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t e;
  pt_t  p;
  logic [23:0] got;

  function automatic string kname(int k);
    case (k)
      K_STATE: return "state";
      K_SL:    return "score_l";
      K_SR:    return "score_r";
      K_WIN:   return "winner";
      K_BX:    return "ball_x";
      K_BY:    return "ball_y";
      K_DX:    return "dir_x";
      K_DY:    return "dir_y";
      K_PL:    return "paddle_l";
      K_PR:    return "paddle_r";
      K_COLOR: return "color";
      default: return "pending_points";
    endcase
  endfunction

  function automatic logic [23:0] obs(int k);
    case (k)
      K_STATE: return 24'(bus.state);
      K_SL:    return 24'(bus.score_l);
      K_SR:    return 24'(bus.score_r);
      K_WIN:   return 24'(bus.winner);
      K_BX:    return 24'(dut.r_ball_x);
      K_BY:    return 24'(dut.r_ball_y);
      K_DX:    return 24'(dut.r_dir_x);
      K_DY:    return 24'(dut.r_dir_y);
      K_PL:    return 24'(dut.r_pl_y);
      K_PR:    return 24'(dut.r_pr_y);
      K_COLOR: return bus.color;
      default: return 24'(pt_q.size());
    endcase
  endfunction

  // Monitor: drains queued expectations and checks every point pulse the DUT raises.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = obs(e.kind);
      n_cmp++;
      if (got !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %0h, want %0h", kname(e.kind), got, e.val);
      end
    end
    if (bus.point_pulse === 1'b1) begin
      n_cmp++;
      if (pt_q.size() == 0) begin
        n_fail++;
        $display("FAIL point_pulse: got unexpected pulse (state %0d), want none", bus.state);
      end else begin
        p = pt_q.pop_front();
        if (bus.score_l !== p.sl || bus.score_r !== p.sr || bus.state !== 3'd3) begin
          n_fail++;
          $display("FAIL point: got score %0d-%0d state %0d, want %0d-%0d state 3",
                   bus.score_l, bus.score_r, bus.state, p.sl, p.sr);
        end
      end
    end
  end

  task automatic ex(input int k, input logic [23:0] v);
    exp_t t;
    t.kind = k;
    t.val  = v;
    exp_q.push_back(t);
  endtask

  task automatic expect_point(input logic [3:0] sl, input logic [3:0] sr);
    pt_t t;
    t.sl = sl;
    t.sr = sr;
    pt_q.push_back(t);
  endtask

  task automatic drain();
    repeat (2) @(negedge clk);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) bus.frame_tick = 1'b1;
      @(negedge clk) bus.frame_tick = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic press_start();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
  endtask

  task automatic probe(input logic [9:0] px, input logic [9:0] py, input logic [23:0] c);
    @(negedge clk);
    bus.x = px;
    bus.y = py;
    @(negedge clk);
    ex(K_COLOR, c);
  endtask

  task automatic chk_ball(input logic [9:0] bx, input logic [9:0] by);
    ex(K_BX, 24'(bx));
    ex(K_BY, 24'(by));
  endtask

  initial begin
    #1_600_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.frame_tick = 1'b0;
    bus.start = 1'b0;
    bus.l_up = 1'b0; bus.l_dn = 1'b0; bus.r_up = 1'b0; bus.r_dn = 1'b0;
    bus.x = 10'd0; bus.y = 10'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset values
    ex(K_STATE, 0); ex(K_SL, 0); ex(K_SR, 0); ex(K_WIN, 0);
    ex(K_PL, 208); ex(K_PR, 208); chk_ball(316, 236);
    ex(K_DX, 1); ex(K_DY, 1); ex(K_COLOR, 0);
    drain();

    // Renderer: ball edges, priority over net, paddles, net stripes
    probe(316, 236, WHT); probe(323, 243, WHT); probe(324, 236, 0); probe(315, 236, 0);
    probe(319, 236, WHT); probe(0, 208, WHT); probe(7, 271, WHT); probe(8, 210, 0);
    probe(0, 272, 0); probe(639, 208, WHT); probe(632, 207, 0); probe(319, 0, GRY);
    probe(320, 15, GRY); probe(320, 16, 0); probe(320, 32, GRY); probe(318, 0, 0);
    drain();

    // Paddles in IDLE: saturation at top and bottom, both buttons hold
    bus.l_up = 1'b1; tick(51); ex(K_PL, 4); drain();
    tick(1); ex(K_PL, 0); drain();
    tick(1); ex(K_PL, 0); drain();
    bus.l_up = 1'b0; bus.l_dn = 1'b1; tick(5); ex(K_PL, 20); drain();
    bus.l_up = 1'b1; tick(2); ex(K_PL, 20); drain();
    bus.l_up = 1'b0; tick(47); ex(K_PL, 208); drain();
    bus.l_dn = 1'b0; bus.r_dn = 1'b1; tick(52); ex(K_PR, 416); drain();
    tick(2); ex(K_PR, 416); drain();
    bus.r_dn = 1'b0; bus.r_up = 1'b1; tick(52); ex(K_PR, 208);
    bus.r_up = 1'b0; ex(K_STATE, 0); chk_ball(316, 236); drain();

    // Rally 1: serve timing, bottom bounce, right misses
    press_start(); ex(K_STATE, 1); drain();
    tick(59); ex(K_STATE, 1); drain();
    tick(1); ex(K_STATE, 2); chk_ball(316, 236); drain();
    tick(1); chk_ball(318, 238); drain();
    tick(116); chk_ball(550, 470); drain();
    tick(1); chk_ball(552, 472); ex(K_DY, 1); drain();
    tick(1); chk_ball(554, 472); ex(K_DY, 0); drain();
    tick(1); chk_ball(556, 470); drain();
    press_start(); ex(K_STATE, 2); drain();
    tick(34); chk_ball(624, 402); drain();
    expect_point(1, 0);
    tick(1);
    ex(K_STATE, 1); ex(K_SL, 1); ex(K_SR, 0); chk_ball(316, 236);
    ex(K_DX, 1); ex(K_DY, 1); drain();

    // Rally 2: right paddle hits, top bounce, left misses
    bus.r_dn = 1'b1; bus.l_dn = 1'b1; tick(23);
    bus.l_dn = 1'b0; tick(17);
    bus.r_dn = 1'b0; tick(20);
    ex(K_STATE, 2); ex(K_PL, 300); ex(K_PR, 368); drain();
    tick(154); chk_ball(624, 402); drain();
    tick(1); chk_ball(624, 400); ex(K_DX, 0); ex(K_DY, 0); drain();
    tick(200); chk_ball(224, 0); ex(K_DY, 0); drain();
    tick(1); chk_ball(222, 0); ex(K_DY, 1); drain();
    tick(1); chk_ball(220, 2); drain();
    tick(105); chk_ball(10, 212); drain();
    tick(1); chk_ball(8, 214); drain();
    expect_point(1, 1);
    tick(1);
    ex(K_STATE, 1); ex(K_SR, 1); ex(K_SL, 1); chk_ball(316, 236);
    ex(K_DX, 0); ex(K_DY, 0); drain();

    // Rally 3: left paddle hits at the edge, right misses
    bus.l_up = 1'b1; tick(60); ex(K_STATE, 2); ex(K_PL, 60); drain();
    tick(5); bus.l_up = 1'b0; ex(K_PL, 40); chk_ball(306, 226); drain();
    tick(112); chk_ball(82, 2); drain();
    tick(1); chk_ball(80, 0); ex(K_DY, 0); drain();
    tick(1); chk_ball(78, 0); ex(K_DY, 1); drain();
    tick(1); chk_ball(76, 2); drain();
    tick(34); chk_ball(8, 70); ex(K_DX, 0); drain();
    tick(1); chk_ball(8, 72); ex(K_DX, 1); drain();
    tick(308); chk_ball(624, 258); drain();
    expect_point(2, 1);
    tick(1);
    ex(K_STATE, 1); ex(K_SL, 2); ex(K_DX, 1); ex(K_DY, 1); drain();

    // Left keeps scoring until the game ends at nine
    bus.r_up = 1'b1; tick(40); bus.r_up = 1'b0; tick(20);
    ex(K_PR, 208); ex(K_STATE, 2); drain();
    for (int k = 3; k <= 9; k++) begin
      if (k > 3) tick(60);
      tick(154);
      expect_point(4'(k), 1);
      tick(1);
      ex(K_SL, 24'(k));
      ex(K_STATE, (k == 9) ? 24'd4 : 24'd1);
      drain();
    end
    ex(K_WIN, 0); ex(K_SR, 1); chk_ball(624, 402); drain();
    probe(624, 402, 0); probe(627, 405, 0); drain();

    // GAME_OVER freezes paddles; start clears scores and re-serves
    bus.r_dn = 1'b1; tick(1); bus.r_dn = 1'b0; ex(K_PR, 208); ex(K_STATE, 4); drain();
    press_start();
    ex(K_STATE, 1); ex(K_SL, 0); ex(K_SR, 0); chk_ball(316, 236); drain();
    tick(65); ex(K_STATE, 2); chk_ball(326, 226); drain();

    // Reset together with frame_tick wins
    @(negedge clk);
    rst = 1'b1;
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    ex(K_STATE, 0); ex(K_PL, 208); chk_ball(316, 236); ex(K_DY, 1); ex(K_DX, 1);
    ex(K_COLOR, 0);
    drain();
    rst = 1'b0;
    @(negedge clk);
    ex(K_PQ, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
